fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the RV32I core. Owns the PC and

---
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction fetch with IF/ID register, one-word skid buffer
//            and redirect handling. Define FETCH_PERF_EN for perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        kill_addr_d  = kill_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        if_pc_d      = if_pc_q;
        if_pc4_d     = if_pc4_q;
        valid_d      = valid_q;

        if (redirect_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            state_d = ST_REQ;
            // An in-flight request cannot be withdrawn: keep presenting its
            // address and drop the word when it finally lands.
            if (state_q == ST_REQ && !imem_ready_i) begin
                kill_d = 1'b1;
                if (!kill_q) begin
                    kill_addr_d = pc_q;
                end
            end else begin
                kill_d = 1'b0;
            end
        end else begin
            if (!stall_i) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (imem_ready_i) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else if (!stall_i) begin
                            instr_d  = imem_rdata_i;
                            if_pc_d  = pc_q;
                            if_pc4_d = pc_q + 32'd4;
                            valid_d  = 1'b1;
                            pc_d     = pc_q + 32'd4;
                        end else begin
                            skid_instr_d = imem_rdata_i;
                            skid_pc_d    = pc_q;
                            pc_d         = pc_q + 32'd4;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        instr_d  = skid_instr_q;
                        if_pc_d  = skid_pc_q;
                        if_pc4_d = skid_pc_q + 32'd4;
                        valid_d  = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            kill_addr_q  <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            instr_q      <= NOP_INSTR;
            if_pc_q      <= 32'h0;
            if_pc4_q     <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            kill_addr_q  <= kill_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            if_pc_q      <= if_pc_d;
            if_pc4_q     <= if_pc4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req_o    = (state_q == ST_REQ);
    assign imem_addr_o   = kill_q ? kill_addr_q : pc_q;
    assign instr_o       = instr_q;
    assign pc_o          = if_pc_q;
    assign pc_plus4_o    = if_pc4_q;
    assign instr_valid_o = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A held IF/ID never reloads, so valid_d outside a stall marks a fresh load.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (valid_d && !stall_i) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (redirect_i) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign fetch_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage (directed table + random run).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b0;
    logic [31:0] xor_key = 32'h0;
    logic        req;
    logic [31:0] addr, rdata, instr, pc, pc4, fcnt, lcnt;
    logic        valid;

    logic        u2_req, u2_valid;
    logic [31:0] u2_addr, u2_instr, u2_pc, u2_pc4, u2_fcnt, u2_lcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address so order errors show.
    assign rdata = addr ^ xor_key;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ready_i(ready), .imem_rdata_i(rdata), .instr_o(instr), .pc_o(pc),
        .pc_plus4_o(pc4), .instr_valid_o(valid), .fetch_cnt_o(fcnt), .flush_cnt_o(lcnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u2 (
        .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .imem_req_o(u2_req), .imem_addr_o(u2_addr),
        .imem_ready_i(1'b1), .imem_rdata_i(u2_addr), .instr_o(u2_instr), .pc_o(u2_pc),
        .pc_plus4_o(u2_pc4), .instr_valid_o(u2_valid), .fetch_cnt_o(u2_fcnt),
        .flush_cnt_o(u2_lcnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;
        int n_deliv, n_flush;
        logic p_vld, p_st, p_rd, p_req, p_rdy, have_prev;
        logic [31:0] p_instr, p_pc, p_addr;

        // st rd rpc rdy | req addr vld instr pc  (outputs seen during that cycle)
        tbl[0]  = '{0, 0, 32'h0,   1, 0, 32'h0,   0, NOP,      32'h0};
        tbl[1]  = '{0, 0, 32'h0,   1, 1, 32'h0,   0, NOP,      32'h0};
        tbl[2]  = '{0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0,    32'h0};
        tbl[3]  = '{0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4,    32'h4};
        tbl[4]  = '{1, 0, 32'h0,   1, 1, 32'hC,   1, 32'h8,    32'h8};
        tbl[5]  = '{1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h8,    32'h8};
        tbl[6]  = '{1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h8,    32'h8};
        tbl[7]  = '{0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h8,    32'h8};
        tbl[8]  = '{0, 0, 32'h0,   1, 1, 32'h10,  1, 32'hC,    32'hC};
        tbl[9]  = '{0, 0, 32'h0,   0, 1, 32'h14,  1, 32'h10,   32'h10};
        tbl[10] = '{0, 1, 32'h100, 0, 1, 32'h14,  0, NOP,      32'h0};
        tbl[11] = '{0, 0, 32'h0,   0, 1, 32'h14,  0, NOP,      32'h0};
        tbl[12] = '{0, 0, 32'h0,   1, 1, 32'h14,  0, NOP,      32'h0};
        tbl[13] = '{0, 0, 32'h0,   1, 1, 32'h100, 0, NOP,      32'h0};
        tbl[14] = '{1, 0, 32'h0,   1, 1, 32'h104, 1, 32'h100,  32'h100};
        tbl[15] = '{1, 1, 32'h103, 1, 0, 32'h0,   1, 32'h100,  32'h100};
        tbl[16] = '{1, 0, 32'h0,   0, 1, 32'h100, 0, NOP,      32'h0};
        tbl[17] = '{0, 0, 32'h0,   1, 1, 32'h100, 0, NOP,      32'h0};
        tbl[18] = '{0, 1, 32'h40,  1, 1, 32'h104, 1, 32'h100,  32'h100};
        tbl[19] = '{0, 0, 32'h0,   1, 1, 32'h40,  0, NOP,      32'h0};
        tbl[20] = '{0, 0, 32'h0,   1, 1, 32'h44,  1, 32'h40,   32'h40};

        // Reset state
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, req}, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_fcnt", fcnt, 32'h0);
        chk("rst_lcnt", lcnt, 32'h0);
        rst_n = 1'b1;

        // Directed table: stream, stall/skid, redirect with kill, flush in HOLD
        for (int k = 0; k < 21; k++) begin
            stall = tbl[k].st; redirect = tbl[k].rd;
            redirect_pc = tbl[k].rpc; ready = tbl[k].rdy;
            #1;
            chk($sformatf("tbl%0d_req", k), {31'h0, req}, {31'h0, tbl[k].req});
            if (tbl[k].req) chk($sformatf("tbl%0d_addr", k), addr, tbl[k].addr);
            chk($sformatf("tbl%0d_valid", k), {31'h0, valid}, {31'h0, tbl[k].vld});
            chk($sformatf("tbl%0d_instr", k), instr, tbl[k].instr);
            if (tbl[k].vld) begin
                chk($sformatf("tbl%0d_pc", k), pc, tbl[k].pc);
                chk($sformatf("tbl%0d_pc4", k), pc4, tbl[k].pc + 32'd4);
            end
            if (k == 1) begin
                chk("wrap_req", {31'h0, u2_req}, 32'h1);
                chk("wrap_addr0", u2_addr, 32'hFFFF_FFFC);
            end
            if (k == 2) begin
                chk("wrap_pc", u2_pc, 32'hFFFF_FFFC);
                chk("wrap_pc4", u2_pc4, 32'h0);
                chk("wrap_addr1", u2_addr, 32'h0);
                chk("wrap_instr", u2_instr, 32'hFFFF_FFFC);
            end
            if (k == 20) begin
                chk("tbl_fcnt", fcnt, PERF ? 32'd8 : 32'd0);
                chk("tbl_lcnt", lcnt, PERF ? 32'd3 : 32'd0);
            end
            @(posedge clk); #1;
        end

        // Reset in the middle of an outstanding request
        stall = 1'b0; redirect = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        chk("midrst_req_before", {31'h0, req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'h0, req}, 32'h0);
        chk("midrst_valid", {31'h0, valid}, 32'h0);
        chk("midrst_instr", instr, NOP);
        chk("midrst_fcnt", fcnt, 32'h0);

        // Ten fetches, then two redirects while a request is stuck
        @(posedge clk); #1;
        rst_n = 1'b1; ready = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        chk("p6_fcnt10", fcnt, PERF ? 32'd10 : 32'd0);
        chk("p6_instr", instr, 32'h24);
        ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        @(posedge clk); #1;
        chk("p6_kill_addr1", addr, 32'h28);
        chk("p6_kill_valid", {31'h0, valid}, 32'h0);
        redirect_pc = 32'h304;
        @(posedge clk); #1;
        redirect = 1'b0;
        chk("p6_kill_addr2", addr, 32'h28);
        chk("p6_fcnt", fcnt, PERF ? 32'd10 : 32'd0);
        chk("p6_lcnt", lcnt, PERF ? 32'd2 : 32'd0);
        ready = 1'b1;
        @(posedge clk); #1;
        chk("p6_target_addr", addr, 32'h304);
        chk("p6_discard_valid", {31'h0, valid}, 32'h0);
        @(posedge clk); #1;
        chk("p6_target_instr", instr, 32'h304);
        chk("p6_target_valid", {31'h0, valid}, 32'h1);

        // Random run against a program-order model
        rst_n = 1'b0; xor_key = 32'hC0DE_0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_pc = 32'h0; n_deliv = 0; n_flush = 0; have_prev = 1'b0;
        p_vld = 0; p_st = 0; p_rd = 0; p_req = 0; p_rdy = 0;
        p_instr = 0; p_pc = 0; p_addr = 0;
        for (int i = 0; i < 3000 && bad < 40; i++) begin
            if (have_prev) begin
                if (p_rd) begin
                    chk("rnd_flush_valid", {31'h0, valid}, 32'h0);
                    chk("rnd_flush_instr", instr, NOP);
                end else if (p_st) begin
                    chk("rnd_stall_instr", instr, p_instr);
                    chk("rnd_stall_pc", pc, p_pc);
                    chk("rnd_stall_valid", {31'h0, valid}, {31'h0, p_vld});
                end
                if (p_req && !p_rdy) begin
                    chk("rnd_req_held", {31'h0, req}, 32'h1);
                    chk("rnd_addr_stable", addr, p_addr);
                end
            end
            stall    = ($urandom_range(0, 3) == 0);
            ready    = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 31) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ?
                          (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            #1;
            if (redirect) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                n_flush++;
            end else if (valid && !stall) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_instr", instr, exp_pc ^ xor_key);
                chk("rnd_pc4", pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            p_vld = valid; p_st = stall; p_rd = redirect; p_req = req; p_rdy = ready;
            p_instr = instr; p_pc = pc; p_addr = addr; have_prev = 1'b1;
            @(posedge clk); #1;
        end
        chk("rnd_progress", {31'h0, (n_deliv > 300)}, 32'h1);
        chk("rnd_lcnt", lcnt, PERF ? 32'(n_flush) : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
